system_rtc_ctrl: RTL and testbench
==================================

Name: system_rtc_ctrl

Overview:
- Avalon-MM slave timekeeper and alarm controller for the alarm clock system.
- Owns the BCD time-of-day (hh:mm:ss) and advances it once per second from a clk prescaler.
- Compares the time against a programmable alarm, drives the ring output and raises an interrupt.
- Drives the six 4-bit digit outputs that feed the display path, replacing per-digit software PIO writes.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per one-second tick (minimum 2).
- ALARM_LEN_S, 60, seconds alarm_out stays asserted after a match (minimum 1).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 2, register select.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- readdata, output, 32, read data; combinational, read latency 0.
- irq, output, 1, interrupt request, level, active-high.
- h_1, h_0, m_1, m_0, s_1, s_0, output, 4 each, BCD digits: hours tens/units, minutes tens/units, seconds tens/units.
- alarm_out, output, 1, alarm ringing indicator.

Behaviour:
- Clocking and reset: one clock domain (clk). reset_n is asynchronous and active-low.
- Reset state: all registers, prescaler, ring counter, digits, alarm_out, irq = 0. Time reads 00:00:00.
- A write is chipselect=1 and write_n=0, and takes effect on the next clk edge. Reads have no side effects.
- Register map:
  - addr0 TIME (RW): [23:20]h1 [19:16]h0 [15:12]m1 [11:8]m0 [7:4]s1 [3:0]s0. Bits [31:24] read 0.
  - addr1 ALARM (RW): [15:12]h1 [11:8]h0 [7:4]m1 [3:0]m0. Alarm seconds are fixed at 00. Bits [31:16] read 0.
  - addr2 CONTROL (RW): bit0 RUN, bit1 ALARM_EN, bit2 IRQ_EN. Other bits read 0.
  - addr3 STATUS: bit0 RINGING (RO); bit1 SEC_FLAG (W1C); bit2 ALARM_FLAG (W1C). Writing 1 to bit0 stops ringing.
- Prescaler:
  - While RUN=1, counts 0..TICKS_PER_SEC-1.
  - The terminal count produces a one-cycle tick and wraps to 0.
  - RUN=0 holds the prescaler and suppresses ticks.
- TIME write:
  - Loads all six digits and clears the prescaler.
  - A TIME write in the same cycle as a tick wins: the written value is stored, no increment occurs, and the next tick is a full TICKS_PER_SEC later.
- Increment on tick, ripple-carry in one cycle (written values are stored unchecked; the wrap rules below self-correct invalid BCD within one tick):
  - s0 >= 9 → 0 with carry, else +1.
  - s1 >= 5 → 0 with carry.
  - m0 >= 9 → 0 with carry.
  - m1 >= 5 → 0 with carry.
  - Hours: if h1 >= 2 and h0 >= 3 → 00; else if h0 >= 9 → h0=0, h1+1; else h0+1.
  - Rollover is 23:59:59 → 00:00:00.
- SEC_FLAG sets on every tick.
- Alarm match:
  - Evaluated only on the time produced by a tick (a TIME write never matches).
  - Condition: ALARM_EN=1 and new hh:mm = ALARM and new ss = 00.
  - On match: RINGING=1, ALARM_FLAG=1, ring counter = ALARM_LEN_S.
- While ringing:
  - Each tick decrements the ring counter; RINGING clears when it reaches 0.
  - RINGING also clears on a STATUS write with bit0=1, or when ALARM_EN is written 0.
  - A match in the same cycle as a stop or clear wins: ringing restarts.
- W1C flag set and clear in the same cycle: set wins.
- Outputs:
  - alarm_out = RINGING.
  - irq = IRQ_EN & (SEC_FLAG | ALARM_FLAG).
  - Digit ports mirror the TIME register directly (no extra latency).
- Reset asserted mid-operation clears everything immediately, including ringing and pending flags.

Test Plan (TICKS_PER_SEC=4, ALARM_LEN_S=2):
- Reset: assert reset_n=0 mid-count → all digits 0, alarm_out=0, irq=0; reads of addr0..3 return 0.
- Rollover: write TIME=0x235959, then CONTROL=0x1 → 4 clks later TIME=0x000000, all digits 0, STATUS=0x2.
- Carry and invalid BCD: TIME=0x095959 → 0x100000 after one tick; TIME=0x00003F → 0x000040 after one tick.
- Alarm: ALARM=0x0700, TIME=0x065959, CONTROL=0x7 → after one tick alarm_out=1, irq=1, STATUS=0x7; after 2 more ticks alarm_out=0, STATUS=0x6.
- Stop/clear: during ringing write STATUS=0x1 → alarm_out=0 next clk; write STATUS=0x6 → irq=0; with CONTROL=0x3 (IRQ_EN=0), flags set but irq stays 0.
- Collision and freeze:
  - Write TIME=0x120000 on the tick cycle → TIME=0x120000, next increment 4 clks later.
  - CONTROL=0x0 → TIME frozen over 20 clks.

Source files
------------

// File: rtl/system_rtc_ctrl_if.sv
// Avalon-MM slave bus bundle for the RTC controller.
// The master drives address/strobes/data; the slave returns combinational readdata.
interface system_rtc_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/system_rtc_ctrl.sv
// BCD time-of-day keeper with alarm, ring timer and interrupt, behind an Avalon-MM slave.
// TIME advances once per TICKS_PER_SEC clocks while RUN is set.
module system_rtc_ctrl #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int ALARM_LEN_S   = 60
) (
  input  logic              clk,
  input  logic              reset_n,
  system_rtc_ctrl_if.slave  bus,
  output logic              irq,
  output logic [3:0]        h_1,
  output logic [3:0]        h_0,
  output logic [3:0]        m_1,
  output logic [3:0]        m_0,
  output logic [3:0]        s_1,
  output logic [3:0]        s_0,
  output logic              alarm_out
);
  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int RW = $clog2(ALARM_LEN_S + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [RW-1:0] RING_LEN  = RW'(ALARM_LEN_S);

  typedef struct packed {
    logic irq_en;
    logic alarm_en;
    logic run;
  } ctrl_t;

  logic [23:0]   time_q, time_d;
  logic [15:0]   alarm_q, alarm_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic          ringing_q, ringing_d;
  logic          sec_flag_q, sec_flag_d;
  logic          alarm_flag_q, alarm_flag_d;

  logic        wr, wr_time, wr_alarm, wr_ctrl, wr_stat;
  logic        tick, match;
  logic [23:0] time_inc;

  // Ripple-carry BCD increment; the >= compares pull out-of-range digits back into range.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [3:0] h1, h0, mi1, mi0, se1, se0;
    logic       c;
    {h1, h0, mi1, mi0, se1, se0} = t;
    c = 1'b0;
    if (se0 >= 4'd9) begin se0 = 4'd0; c = 1'b1; end
    else se0 = se0 + 4'd1;
    if (c) begin
      c = 1'b0;
      if (se1 >= 4'd5) begin se1 = 4'd0; c = 1'b1; end
      else se1 = se1 + 4'd1;
    end
    if (c) begin
      c = 1'b0;
      if (mi0 >= 4'd9) begin mi0 = 4'd0; c = 1'b1; end
      else mi0 = mi0 + 4'd1;
    end
    if (c) begin
      c = 1'b0;
      if (mi1 >= 4'd5) begin mi1 = 4'd0; c = 1'b1; end
      else mi1 = mi1 + 4'd1;
    end
    if (c) begin
      if (h1 >= 4'd2 && h0 >= 4'd3) begin h1 = 4'd0; h0 = 4'd0; end
      else if (h0 >= 4'd9) begin h0 = 4'd0; h1 = h1 + 4'd1; end
      else h0 = h0 + 4'd1;
    end
    return {h1, h0, mi1, mi0, se1, se0};
  endfunction

  assign wr       = bus.chipselect & ~bus.write_n;
  assign wr_time  = wr && (bus.address == 2'd0);
  assign wr_alarm = wr && (bus.address == 2'd1);
  assign wr_ctrl  = wr && (bus.address == 2'd2);
  assign wr_stat  = wr && (bus.address == 2'd3);

  assign tick     = ctrl_q.run && (presc_q == PRESC_MAX);
  assign time_inc = bcd_inc(time_q);
  // A TIME write on a tick suppresses the increment, so it can never produce a match.
  assign match    = tick && !wr_time && ctrl_q.alarm_en &&
                    (time_inc[23:8] == alarm_q) && (time_inc[7:0] == 8'h00);

  always_comb begin
    time_d       = time_q;
    alarm_d      = alarm_q;
    ctrl_d       = ctrl_q;
    presc_d      = presc_q;
    ring_cnt_d   = ring_cnt_q;
    ringing_d    = ringing_q;
    sec_flag_d   = sec_flag_q;
    alarm_flag_d = alarm_flag_q;

    if (wr_time) begin
      time_d  = bus.writedata[23:0];
      presc_d = '0;
    end else begin
      if (ctrl_q.run) presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) time_d = time_inc;
    end

    if (wr_alarm) alarm_d = bus.writedata[15:0];
    if (wr_ctrl)  ctrl_d  = ctrl_t'(bus.writedata[2:0]);

    if (ringing_q && tick && ring_cnt_q != '0) begin
      ring_cnt_d = ring_cnt_q - RW'(1);
      if (ring_cnt_q == RW'(1)) ringing_d = 1'b0;
    end
    if (wr_stat && bus.writedata[0])  ringing_d = 1'b0;
    if (wr_ctrl && !bus.writedata[1]) ringing_d = 1'b0;
    if (match) begin
      ringing_d  = 1'b1;
      ring_cnt_d = RING_LEN;
    end

    // Clear first so a same-cycle set wins.
    if (wr_stat && bus.writedata[1]) sec_flag_d   = 1'b0;
    if (wr_stat && bus.writedata[2]) alarm_flag_d = 1'b0;
    if (tick)  sec_flag_d   = 1'b1;
    if (match) alarm_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      time_q       <= '0;
      alarm_q      <= '0;
      ctrl_q       <= '0;
      presc_q      <= '0;
      ring_cnt_q   <= '0;
      ringing_q    <= 1'b0;
      sec_flag_q   <= 1'b0;
      alarm_flag_q <= 1'b0;
    end else begin
      time_q       <= time_d;
      alarm_q      <= alarm_d;
      ctrl_q       <= ctrl_d;
      presc_q      <= presc_d;
      ring_cnt_q   <= ring_cnt_d;
      ringing_q    <= ringing_d;
      sec_flag_q   <= sec_flag_d;
      alarm_flag_q <= alarm_flag_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0: bus.readdata = {8'h00, time_q};
      2'd1: bus.readdata = {16'h0000, alarm_q};
      2'd2: bus.readdata = {29'd0, ctrl_q};
      2'd3: bus.readdata = {29'd0, alarm_flag_q, sec_flag_q, ringing_q};
      default: bus.readdata = '0;
    endcase
  end

  assign {h_1, h_0, m_1, m_0, s_1, s_0} = time_q;
  assign alarm_out = ringing_q;
  assign irq       = ctrl_q.irq_en & (sec_flag_q | alarm_flag_q);
endmodule

// File: tb/tb_system_rtc_ctrl.sv
// Self-checking bench for system_rtc_ctrl: register table, directed corner sequences,
// and randomized traffic against a seconds-of-day reference model.
module tb_system_rtc_ctrl;
  localparam int TPS  = 4;
  localparam int ALEN = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq, alarm_out;
  logic [3:0] h_1, h_0, m_1, m_0, s_1, s_0;
  int total = 0;
  int bad = 0;

  system_rtc_ctrl_if bus ();

  system_rtc_ctrl #(.TICKS_PER_SEC(TPS), .ALARM_LEN_S(ALEN)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq),
    .h_1(h_1), .h_0(h_0), .m_1(m_1), .m_0(m_0), .s_1(s_1), .s_0(s_0),
    .alarm_out(alarm_out)
  );

  always #5 clk = ~clk;

  // Reference model: time as seconds of day, prescaler as a plain cycle count.
  int m_secs, m_cnt, m_left;
  bit m_run, m_aen, m_ien, m_ring, m_sflag, m_aflag;
  logic [15:0] m_alarm;

  function automatic logic [23:0] sec2bcd(input int s);
    int h, mi, se;
    h = s / 3600; mi = (s / 60) % 60; se = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
  endfunction

  function automatic int bcd2sec(input logic [23:0] b);
    return (int'(b[23:20]) * 10 + int'(b[19:16])) * 3600 +
           (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 +
           int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic model_reset();
    m_secs = 0; m_cnt = 0; m_left = 0; m_alarm = '0;
    m_run = 0; m_aen = 0; m_ien = 0; m_ring = 0; m_sflag = 0; m_aflag = 0;
  endtask

  task automatic model_step(input bit w, input logic [1:0] a, input logic [31:0] d);
    bit tick, twr, match;
    int ns;
    logic [23:0] nb;
    if (!reset_n) begin model_reset(); return; end
    tick = m_run && (m_cnt == TPS - 1);
    twr  = w && (a == 2'd0);
    if (twr) m_cnt = 0;
    else if (m_run) m_cnt = tick ? 0 : m_cnt + 1;
    ns = twr ? bcd2sec(d[23:0]) : (tick ? (m_secs + 1) % 86400 : m_secs);
    nb = sec2bcd(ns);
    match = tick && !twr && m_aen && (ns % 60 == 0) && (nb[23:8] == m_alarm);
    if (m_ring && tick) begin m_left--; if (m_left == 0) m_ring = 0; end
    if (w && a == 2'd3 && d[0]) m_ring = 0;
    if (w && a == 2'd2 && !d[1]) m_ring = 0;
    if (match) begin m_ring = 1; m_left = ALEN; end
    if (w && a == 2'd3) begin
      if (d[1]) m_sflag = 0;
      if (d[2]) m_aflag = 0;
    end
    if (tick) m_sflag = 1;
    if (match) m_aflag = 1;
    if (w && a == 2'd1) m_alarm = d[15:0];
    if (w && a == 2'd2) {m_ien, m_aen, m_run} = d[2:0];
    m_secs = ns;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input bit w, input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = w; bus.write_n = !w; bus.writedata = d;
    @(posedge clk);
    model_step(w, a, d);
    #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1;
    v = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  function automatic logic [23:0] digits();
    return {h_1, h_0, m_1, m_0, s_1, s_0};
  endfunction

  typedef struct {
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[8];
  logic [31:0] v;

  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    model_reset();
    vt[0] = '{2'd0, 32'hFF12_3456, 32'h0012_3456};
    vt[1] = '{2'd1, 32'hFFFF_0745, 32'h0000_0745};
    vt[2] = '{2'd2, 32'hFFFF_FFFA, 32'h0000_0002};
    vt[3] = '{2'd2, 32'h0000_0006, 32'h0000_0006};
    vt[4] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[5] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
    vt[6] = '{2'd1, 32'h0000_0000, 32'h0000_0000};
    vt[7] = '{2'd2, 32'h0000_0000, 32'h0000_0000};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Register table with RUN=0.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, vt[i].a, vt[i].wd);
      rd(vt[i].a, v);
      chk($sformatf("table%0d", i), v, vt[i].exp);
    end

    // Reset asserted mid-count clears everything at once.
    cyc(1'b1, 2'd0, 32'h0012_3456);
    cyc(1'b1, 2'd2, 32'h0000_0007);
    idle(6);
    reset_n = 1'b0;
    #1;
    chk("rst_digits", {8'd0, digits()}, 32'd0);
    chk("rst_alarm_irq", {30'd0, alarm_out, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk($sformatf("rst_read%0d", a), v, 32'd0);
    end
    idle(1);
    reset_n = 1'b1;
    model_reset();

    // Rollover.
    cyc(1'b1, 2'd0, 32'h0023_5959);
    cyc(1'b1, 2'd2, 32'h0000_0001);
    idle(3);
    rd(2'd0, v); chk("roll_before", v, 32'h0023_5959);
    idle(1);
    rd(2'd0, v); chk("roll_time", v, 32'd0);
    chk("roll_digits", {8'd0, digits()}, 32'd0);
    rd(2'd3, v); chk("roll_status", v, 32'h2);

    // Carry chain and invalid BCD self-correction.
    cyc(1'b1, 2'd0, 32'h0009_5959);
    idle(4);
    rd(2'd0, v); chk("carry_h", v, 32'h0010_0000);
    cyc(1'b1, 2'd0, 32'h0000_003F);
    idle(4);
    rd(2'd0, v); chk("bad_bcd", v, 32'h0000_0040);
    cyc(1'b1, 2'd0, 32'h0019_5959);
    idle(4);
    rd(2'd0, v); chk("carry_h1", v, 32'h0020_0000);

    // Alarm ring and timeout.
    cyc(1'b1, 2'd2, 32'h0);
    cyc(1'b1, 2'd3, 32'h6);
    cyc(1'b1, 2'd1, 32'h0700);
    cyc(1'b1, 2'd0, 32'h0006_5959);
    cyc(1'b1, 2'd2, 32'h7);
    idle(3);
    chk("alarm_pre", {31'd0, alarm_out}, 32'd0);
    idle(1);
    chk("alarm_ring", {30'd0, alarm_out, irq}, 32'h3);
    rd(2'd3, v); chk("alarm_status", v, 32'h7);
    idle(4);
    chk("alarm_still", {31'd0, alarm_out}, 32'd1);
    idle(4);
    chk("alarm_off", {31'd0, alarm_out}, 32'd0);
    rd(2'd3, v); chk("alarm_status2", v, 32'h6);

    // Stop by STATUS write, flag clear, IRQ_EN masking.
    cyc(1'b1, 2'd0, 32'h0006_5959);
    idle(4);
    chk("stop_ringing", {31'd0, alarm_out}, 32'd1);
    cyc(1'b1, 2'd3, 32'h1);
    chk("stop_off", {31'd0, alarm_out}, 32'd0);
    cyc(1'b1, 2'd3, 32'h6);
    chk("clr_irq", {31'd0, irq}, 32'd0);
    rd(2'd3, v); chk("clr_status", v, 32'h0);
    cyc(1'b1, 2'd2, 32'h3);
    idle(4);
    rd(2'd3, v); chk("mask_status", v[1:0] == 2'b10 ? 32'h1 : 32'h0, 32'h1);
    chk("mask_irq", {31'd0, irq}, 32'd0);

    // Alarm stopped by ALARM_EN=0 write.
    cyc(1'b1, 2'd0, 32'h0006_5959);
    idle(4);
    chk("aen_ringing", {31'd0, alarm_out}, 32'd1);
    cyc(1'b1, 2'd2, 32'h1);
    chk("aen_off", {31'd0, alarm_out}, 32'd0);

    // TIME write on the tick cycle wins, prescaler restarts.
    cyc(1'b1, 2'd0, 32'h0);
    idle(3);
    cyc(1'b1, 2'd0, 32'h0012_0000);
    rd(2'd0, v); chk("coll_time", v, 32'h0012_0000);
    idle(3);
    rd(2'd0, v); chk("coll_hold", v, 32'h0012_0000);
    idle(1);
    rd(2'd0, v); chk("coll_next", v, 32'h0012_0001);

    // Freeze with RUN=0.
    cyc(1'b1, 2'd2, 32'h0);
    idle(20);
    rd(2'd0, v); chk("freeze", v, 32'h0012_0001);

    // Randomized traffic against the model.
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    model_reset();
    for (int seg = 0; seg < 10; seg++) begin
      int t, am;
      logic [23:0] ab;
      t  = int'($urandom % 24) * 3600 + int'($urandom % 60) * 60 + 50 + int'($urandom % 10);
      am = (t / 60 + 1) % 1440;
      ab = sec2bcd(am * 60);
      cyc(1'b1, 2'd0, {8'd0, sec2bcd(t)});
      cyc(1'b1, 2'd1, {16'd0, ab[23:8]});
      cyc(1'b1, 2'd2, 32'(1 | ($urandom % 8)));
      for (int c = 0; c < 150; c++) begin
        logic [1:0] ra;
        logic [31:0] rdat, exp;
        logic [23:0] rb;
        if ($urandom % 20 == 0) begin
          ra = 2'($urandom % 4);
          case (ra)
            2'd0: rdat = {8'd0, sec2bcd(int'($urandom % 86400))};
            2'd1: begin rb = sec2bcd(int'($urandom % 1440) * 60); rdat = {16'd0, rb[23:8]}; end
            2'd2: rdat = ($urandom % 5 != 0) ? 32'(1 | ($urandom % 8)) : 32'($urandom % 8);
            default: rdat = 32'($urandom % 8);
          endcase
          cyc(1'b1, ra, rdat);
        end else begin
          cyc(1'b0, 2'd0, 32'd0);
        end
        chk("rnd_outs", {6'd0, alarm_out, irq, digits()},
            {6'd0, m_ring, m_ien & (m_sflag | m_aflag), sec2bcd(m_secs)});
        ra = 2'($urandom % 4);
        rd(ra, v);
        case (ra)
          2'd0: exp = {8'd0, sec2bcd(m_secs)};
          2'd1: exp = {16'd0, m_alarm};
          2'd2: exp = {29'd0, m_ien, m_aen, m_run};
          default: exp = {29'd0, m_aflag, m_sflag, m_ring};
        endcase
        chk($sformatf("rnd_read%0d", ra), v, exp);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
